// File: rtl/cfg_target_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cfg_target_pkg
// Purpose  : Shared FSM state encodings and CRC-16-CCITT helpers for the
//            config_reg_target_emu chip-side shift-register model.
// Revision : 1.0  initial release
// ============================================================================
package cfg_target_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_RESET = 2'd0;
    localparam state_t ST_IDLE  = 2'd1;
    localparam state_t ST_SHIFT = 2'd2;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // One MSB-first bit of CRC-16-CCITT.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/config_reg_target_emu_if.sv
`default_nettype none
// ============================================================================
// Module   : config_reg_target_emu_if
// Purpose  : Serial config bus between the FPGA driver (master) and the
//            chip-side target model (slave). CFG_TARGET_CRC_EN adds CRC outputs.
// Revision : 1.0  initial release
// ============================================================================
interface config_reg_target_emu_if #(
    parameter int CONFIG_REG_WIDTH = 5164,
    parameter int CNT_WIDTH        = 16
);
    logic                        SuperpixSel;
    logic                        ConfigClk;
    logic                        Reset_not;
    logic                        ConfigIn;
    logic                        ConfigLoad;
    logic                        ConfigOut;
    logic [CONFIG_REG_WIDTH-1:0] ParallelOut;
    logic                        sel_latched;
    logic                        load_pulse;
    logic [CNT_WIDTH-1:0]        shift_count;
    logic                        len_err;
`ifdef CFG_TARGET_CRC_EN
    logic [15:0]                 crc_out;
    logic [15:0]                 crc_latched;

    modport master (
        output SuperpixSel, ConfigClk, Reset_not, ConfigIn, ConfigLoad,
        input  ConfigOut, ParallelOut, sel_latched, load_pulse, shift_count, len_err,
        input  crc_out, crc_latched
    );
    modport slave (
        input  SuperpixSel, ConfigClk, Reset_not, ConfigIn, ConfigLoad,
        output ConfigOut, ParallelOut, sel_latched, load_pulse, shift_count, len_err,
        output crc_out, crc_latched
    );
`else
    modport master (
        output SuperpixSel, ConfigClk, Reset_not, ConfigIn, ConfigLoad,
        input  ConfigOut, ParallelOut, sel_latched, load_pulse, shift_count, len_err
    );
    modport slave (
        input  SuperpixSel, ConfigClk, Reset_not, ConfigIn, ConfigLoad,
        output ConfigOut, ParallelOut, sel_latched, load_pulse, shift_count, len_err
    );
`endif
endinterface
`default_nettype wire

// File: rtl/cfg_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : cfg_sync_edge
// Purpose  : Multi-flop synchronizer for one async input plus a rise detector.
// Revision : 1.0  initial release
// ============================================================================
module cfg_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_async,
    output logic      o_level,
    output logic      o_rise
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
endmodule
`default_nettype wire

// File: rtl/config_reg_target_emu.sv
`default_nettype none
// ============================================================================
// Module   : config_reg_target_emu
// Purpose  : Chip-side model of the serial config shift register; oversamples
//            the driver's pins and latches ParallelOut on load.
//            CFG_TARGET_CRC_EN adds a running/latched CRC-16-CCITT.
// Revision : 1.0  initial release
// ============================================================================
module config_reg_target_emu
    import cfg_target_pkg::*;
#(
    parameter int CONFIG_REG_WIDTH = 5164,
    parameter int SYNC_STAGES      = 2,
    parameter int CNT_WIDTH        = 16
) (
    input  wire logic               S_AXI_ACLK,
    input  wire logic               S_AXI_ARESET,
    config_reg_target_emu_if.slave  bus
);
    localparam int c_n_in  = 5;
    localparam int c_i_sel = 0;
    localparam int c_i_clk = 1;
    localparam int c_i_rst = 2;
    localparam int c_i_din = 3;
    localparam int c_i_ld  = 4;
    localparam logic [CNT_WIDTH-1:0] c_full_cnt = CNT_WIDTH'(CONFIG_REG_WIDTH);

    logic [c_n_in-1:0] w_async;
    logic [c_n_in-1:0] w_level;
    logic [c_n_in-1:0] w_rise;

    assign w_async = {bus.ConfigLoad, bus.ConfigIn, bus.Reset_not, bus.ConfigClk, bus.SuperpixSel};

    for (genvar gi = 0; gi < c_n_in; gi++) begin : g_sync
        cfg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk     (S_AXI_ACLK),
            .rst     (S_AXI_ARESET),
            .i_async (w_async[gi]),
            .o_level (w_level[gi]),
            .o_rise  (w_rise[gi])
        );
    end

    logic w_unused_rise;
    assign w_unused_rise = &{1'b0, w_rise[c_i_sel], w_rise[c_i_rst], w_rise[c_i_din]};

    logic w_shift_en, w_load_en, w_rst_n;
    assign w_shift_en = w_rise[c_i_clk];
    assign w_load_en  = w_rise[c_i_ld];
    assign w_rst_n    = w_level[c_i_rst];

    state_t                      r_state;
    logic [CONFIG_REG_WIDTH-1:0] r_sr;
    logic [CONFIG_REG_WIDTH-1:0] r_parallel;
    logic                        r_config_out;
    logic                        r_sel;
    logic                        r_load_pulse;
    logic [CNT_WIDTH-1:0]        r_count;
    logic                        r_len_err;

    // Post-shift values so a coincident load captures the newest bit.
    logic [CONFIG_REG_WIDTH-1:0] w_sr_next;
    logic [CNT_WIDTH-1:0]        w_cnt_next;
    assign w_sr_next  = w_shift_en ? {r_sr[CONFIG_REG_WIDTH-2:0], w_level[c_i_din]} : r_sr;
    assign w_cnt_next = (w_shift_en && (r_count != '1)) ? r_count + CNT_WIDTH'(1) : r_count;

    logic w_active;
    assign w_active = w_rst_n && (r_state != ST_RESET);

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_state      <= ST_RESET;
            r_sr         <= '0;
            r_parallel   <= '0;
            r_config_out <= 1'b0;
            r_sel        <= 1'b0;
            r_load_pulse <= 1'b0;
            r_count      <= '0;
            r_len_err    <= 1'b0;
        end else begin
            r_load_pulse <= 1'b0;
            if (!w_rst_n) begin
                r_state      <= ST_RESET;
                r_sr         <= '0;
                r_parallel   <= '0;
                r_config_out <= 1'b0;
                r_count      <= '0;
                r_len_err    <= 1'b0;
            end else if (r_state == ST_RESET) begin
                r_state <= ST_IDLE;
            end else begin
                r_sr         <= w_sr_next;
                r_config_out <= w_sr_next[CONFIG_REG_WIDTH-1];
                r_count      <= w_cnt_next;
                if (w_shift_en && (r_state == ST_IDLE))
                    r_state <= ST_SHIFT;
                if (w_load_en) begin
                    r_parallel   <= w_sr_next;
                    r_sel        <= w_level[c_i_sel];
                    r_load_pulse <= 1'b1;
                    r_len_err    <= r_len_err | (w_cnt_next != c_full_cnt);
                    r_count      <= '0;
                    r_state      <= ST_IDLE;
                end
            end
        end
    end

    assign bus.ConfigOut   = r_config_out;
    assign bus.ParallelOut = r_parallel;
    assign bus.sel_latched = r_sel;
    assign bus.load_pulse  = r_load_pulse;
    assign bus.shift_count = r_count;
    assign bus.len_err     = r_len_err;

`ifdef CFG_TARGET_CRC_EN
    logic [15:0] r_crc;
    logic [15:0] r_crc_latched;
    logic [15:0] w_crc_next;

    assign w_crc_next = w_shift_en ? crc16_step(r_crc, w_level[c_i_din]) : r_crc;

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_crc         <= CRC16_INIT;
            r_crc_latched <= CRC16_INIT;
        end else if (!w_rst_n) begin
            r_crc         <= CRC16_INIT;
            r_crc_latched <= CRC16_INIT;
        end else if (w_active) begin
            if (w_load_en) begin
                r_crc_latched <= w_crc_next;
                r_crc         <= CRC16_INIT;
            end else begin
                r_crc <= w_crc_next;
            end
        end
    end

    assign bus.crc_out     = r_crc;
    assign bus.crc_latched = r_crc_latched;
`else
    logic w_unused_active;
    assign w_unused_active = w_active;
`endif
endmodule
`default_nettype wire

// File: tb/tb_config_reg_target_emu.sv
`default_nettype none
// ============================================================================
// Module   : tb_config_reg_target_emu
// Purpose  : Directed self-checking bench for config_reg_target_emu (W=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_config_reg_target_emu;
    localparam int c_w    = 8;
    localparam int c_cntw = 16;
    localparam int c_half = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    config_reg_target_emu_if #(.CONFIG_REG_WIDTH(c_w), .CNT_WIDTH(c_cntw)) bus ();

    config_reg_target_emu #(
        .CONFIG_REG_WIDTH (c_w),
        .SYNC_STAGES      (2),
        .CNT_WIDTH        (c_cntw)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .bus          (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input logic b);
        bus.ConfigIn = b;
        wait_cycles(c_half);
        bus.ConfigClk = 1'b1;
        wait_cycles(c_half);
        bus.ConfigClk = 1'b0;
    endtask

    task automatic shift_byte(input logic [7:0] v, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) shift_bit(v[i]);
    endtask

    // Load strobe; counts load_pulse cycles seen across the whole strobe.
    task automatic do_load(output int pulses);
        pulses = 0;
        wait_cycles(c_half);
        bus.ConfigLoad = 1'b1;
        repeat (c_half) begin
            @(negedge clk);
            if (bus.load_pulse === 1'b1) pulses++;
        end
        bus.ConfigLoad = 1'b0;
        repeat (c_half) begin
            @(negedge clk);
            if (bus.load_pulse === 1'b1) pulses++;
        end
    endtask

    task automatic pulse_reset_not();
        bus.Reset_not = 1'b0;
        wait_cycles(c_half);
        check("len_err_clr_by_reset_not", 32'(bus.len_err), 32'h0);
        bus.Reset_not = 1'b1;
        wait_cycles(c_half);
    endtask

    function automatic logic [15:0] crc_ref(input logic [7:0] v);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 7; i >= 0; i--)
            c = {c[14:0], 1'b0} ^ ((c[15] ^ v[i]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction

    initial begin
        int          np;
        logic [7:0]  a5;
        a5 = 8'hA5;
        bus.SuperpixSel = 1'b0;
        bus.ConfigClk   = 1'b0;
        bus.Reset_not   = 1'b0;
        bus.ConfigIn    = 1'b0;
        bus.ConfigLoad  = 1'b0;

        wait_cycles(3);
        check("rst_parallel",   32'(bus.ParallelOut), 32'h0);
        check("rst_config_out", 32'(bus.ConfigOut),   32'h0);
        check("rst_count",      32'(bus.shift_count), 32'h0);
        check("rst_len_err",    32'(bus.len_err),     32'h0);
        check("rst_load_pulse", 32'(bus.load_pulse),  32'h0);
        check("rst_sel",        32'(bus.sel_latched), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.Reset_not = 1'b1;
        wait_cycles(c_half);

        // 1: full-length load of 0xA5
        bus.SuperpixSel = 1'b1;
        shift_byte(8'hA5, 8);
        wait_cycles(5);
        check("t1_count_before_load", 32'(bus.shift_count), 32'd8);
        do_load(np);
        check("t1_parallel",   32'(bus.ParallelOut), 32'hA5);
        check("t1_pulses",     32'(np),              32'd1);
        check("t1_count",      32'(bus.shift_count), 32'd0);
        check("t1_len_err",    32'(bus.len_err),     32'h0);
        check("t1_sel",        32'(bus.sel_latched), 32'h1);

        // 2: overshift; A5 falls out through ConfigOut MSB-first
        shift_byte(8'hA5, 8);
        wait_cycles(5);
        for (int i = 7; i >= 0; i--) begin
            check("t2_config_out", 32'(bus.ConfigOut), 32'(a5[i]));
            shift_bit(1'b0);
            wait_cycles(5);
        end
        check("t2_config_out_final", 32'(bus.ConfigOut),   32'h0);
        check("t2_count16",          32'(bus.shift_count), 32'd16);
        do_load(np);
        check("t2_parallel",         32'(bus.ParallelOut), 32'h00);
        check("t2_len_err",          32'(bus.len_err),     32'h1);
        pulse_reset_not();

        // 3: short shift sets sticky len_err
        shift_byte(8'hB0, 5);
        do_load(np);
        check("t3_parallel_partial", 32'(bus.ParallelOut), 32'h16);
        check("t3_len_err",          32'(bus.len_err),     32'h1);
        shift_byte(8'h3C, 8);
        do_load(np);
        check("t3_parallel_full",    32'(bus.ParallelOut), 32'h3C);
        check("t3_len_err_sticky",   32'(bus.len_err),     32'h1);
        pulse_reset_not();
        check("t3_parallel_cleared", 32'(bus.ParallelOut), 32'h00);

        // 4: 8th clock rise coincident with load rise
        shift_byte(8'h5B, 7);
        bus.ConfigIn = 1'b1;
        wait_cycles(c_half);
        bus.ConfigClk  = 1'b1;
        bus.ConfigLoad = 1'b1;
        np = 0;
        repeat (c_half) begin
            @(negedge clk);
            if (bus.load_pulse === 1'b1) np++;
        end
        bus.ConfigClk  = 1'b0;
        bus.ConfigLoad = 1'b0;
        wait_cycles(c_half);
        check("t4_parallel", 32'(bus.ParallelOut), 32'h5B);
        check("t4_pulses",   32'(np),              32'd1);
        check("t4_len_err",  32'(bus.len_err),     32'h0);
        check("t4_count",    32'(bus.shift_count), 32'd0);

        // 5: Reset_not aborts mid-shift and masks edges while low
        shift_byte(8'hF0, 4);
        wait_cycles(5);
        check("t5_count4", 32'(bus.shift_count), 32'd4);
        bus.Reset_not = 1'b0;
        wait_cycles(3);
        check("t5_count_cleared",    32'(bus.shift_count), 32'd0);
        check("t5_parallel_cleared", 32'(bus.ParallelOut), 32'h00);
        shift_bit(1'b1);
        shift_bit(1'b1);
        do_load(np);
        check("t5_count_ignored",    32'(bus.shift_count), 32'd0);
        check("t5_parallel_ignored", 32'(bus.ParallelOut), 32'h00);
        check("t5_no_pulse",         32'(np),              32'd0);
        bus.Reset_not = 1'b1;
        wait_cycles(c_half);
        shift_byte(8'hC3, 8);
        do_load(np);
        check("t5_parallel_after", 32'(bus.ParallelOut), 32'hC3);
        check("t5_len_err_after",  32'(bus.len_err),     32'h0);

`ifdef CFG_TARGET_CRC_EN
        // 6: CRC over 0x31
        shift_byte(8'h31, 8);
        do_load(np);
        check("t6_crc_latched", 32'(bus.crc_latched), 32'(crc_ref(8'h31)));
        check("t6_crc_reinit",  32'(bus.crc_out),     32'hFFFF);
        check("t6_parallel",    32'(bus.ParallelOut), 32'h31);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
